// File: rtl/motion_sensor_filter.sv
// PIR sensor conditioning: 2-flop sync, debounce and a
// hold-extended presence FSM with edge pulses and event count.
module motion_sensor_filter #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int HOLD_SECONDS    = 30
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        GPIO,
  output logic        motion,
  output logic        motion_rise,
  output logic        motion_fall,
  output logic [7:0]  hold_remaining,
  output logic [15:0] event_count
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] P_MAX   = PW'(CLK_HZ - 1);
  localparam logic [19:0]   DB_MAX  = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    HOLD_LD = 8'(HOLD_SECONDS);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  state_t          state, next_state;
  logic            s1, s2;
  logic            db;
  logic [19:0]     db_cnt;
  logic [PW-1:0]   presc, presc_d;
  logic            tick;
  logic            motion_d, rise_d, fall_d;
  logic [7:0]      hold_d;
  logic [15:0]     count_d;

  // Two-flop synchronizer; the only logic touching GPIO.
  always_ff @(posedge CLOCK_50 or posedge reset_n) begin
    if (reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= GPIO;
      s2 <= s1;
    end
  end

  // Debounce: toggle db after DEBOUNCE_CYCLES differing edges in a row.
  always_ff @(posedge CLOCK_50 or posedge reset_n) begin
    if (reset_n) begin
      db_cnt <= '0;
      db     <= 1'b0;
    end else if (s2 == db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_MAX) begin
      db_cnt <= '0;
      db     <= ~db;
    end else begin
      db_cnt <= db_cnt + 20'd1;
    end
  end

  assign tick = (state == HOLD) && (presc == P_MAX);

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset_n) begin
    if (reset_n) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic; db wins over a simultaneous tick in HOLD.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (db) next_state = ACTIVE;
      ACTIVE:  if (!db) next_state = (HOLD_SECONDS == 0) ? IDLE : HOLD;
      HOLD: begin
        if (db)
          next_state = ACTIVE;
        else if (tick && hold_remaining == 8'd1)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs and the prescaler.
  always_comb begin
    motion_d = motion;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    hold_d   = hold_remaining;
    count_d  = event_count;
    presc_d  = '0;
    unique case (state)
      IDLE: begin
        if (db) begin
          motion_d = 1'b1;
          rise_d   = 1'b1;
          if (event_count != 16'hFFFF)
            count_d = event_count + 16'd1;
        end
      end
      ACTIVE: begin
        if (!db) begin
          if (HOLD_SECONDS == 0) begin
            motion_d = 1'b0;
            fall_d   = 1'b1;
          end else begin
            hold_d = HOLD_LD;
          end
        end
      end
      HOLD: begin
        if (db) begin
          hold_d = 8'd0;
        end else if (tick) begin
          hold_d = hold_remaining - 8'd1;
          if (hold_remaining == 8'd1) begin
            motion_d = 1'b0;
            fall_d   = 1'b1;
          end
        end else begin
          presc_d = presc + PW'(1);
        end
      end
      default: hold_d = 8'd0;
    endcase
  end

  // Output and prescaler registers.
  always_ff @(posedge CLOCK_50 or posedge reset_n) begin
    if (reset_n) begin
      motion         <= 1'b0;
      motion_rise    <= 1'b0;
      motion_fall    <= 1'b0;
      hold_remaining <= 8'd0;
      event_count    <= 16'd0;
      presc          <= '0;
    end else begin
      motion         <= motion_d;
      motion_rise    <= rise_d;
      motion_fall    <= fall_d;
      hold_remaining <= hold_d;
      event_count    <= count_d;
      presc          <= presc_d;
    end
  end

endmodule

// File: tb/tb_motion_sensor_filter.sv
// Randomized bench for motion_sensor_filter against a
// window/deadline reference model of the sensor filter.
module tb_motion_sensor_filter;

  localparam int CLK_HZ = 10;
  localparam int DB     = 4;
  localparam int HS     = 3;
  localparam int T      = HS * CLK_HZ;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        gpio = 1'b0;
  logic        motion, rise, fall;
  logic [7:0]  hold;
  logic [15:0] ec;

  int nchk = 0;
  int nerr = 0;

  motion_sensor_filter #(
    .CLK_HZ(CLK_HZ),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_SECONDS(HS)
  ) dut (
    .CLOCK_50(clk),
    .reset_n(rst),
    .GPIO(gpio),
    .motion(motion),
    .motion_rise(rise),
    .motion_fall(fall),
    .hold_remaining(hold),
    .event_count(ec)
  );

  always #5 clk = ~clk;

  // Reference model: raw sample window, expiry deadline.
  bit          h[DB+2];
  bit          m_db, m_db1, m_mot, m_rise, m_fall;
  int          m_k, m_fdl, m_hold;
  int unsigned m_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    foreach (h[i]) h[i] = 1'b0;
    m_db = 0; m_db1 = 0; m_mot = 0;
    m_rise = 0; m_fall = 0;
    m_fdl = 0; m_hold = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit pm;
    bit diff;
    m_k++;
    if (rst) begin
      model_clear();
      return;
    end
    for (int j = DB + 1; j > 0; j--) h[j] = h[j-1];
    h[0] = gpio;
    pm = m_mot;
    if (pm && m_db1 && !m_db) m_fdl = m_k + T;
    m_mot  = m_db || (pm && m_k < m_fdl);
    m_rise = m_mot && !pm;
    m_fall = !m_mot && pm;
    if (m_rise && m_cnt != 65535) m_cnt++;
    m_hold = (m_mot && !m_db) ? (m_fdl - m_k + CLK_HZ - 1) / CLK_HZ : 0;
    diff = 1;
    for (int j = 2; j <= DB + 1; j++)
      if (h[j] == m_db) diff = 0;
    m_db1 = m_db;
    if (diff) m_db = !m_db;
  endtask

  task automatic check_outputs();
    chk("motion", int'(motion), int'(m_mot));
    chk("motion_rise", int'(rise), int'(m_rise));
    chk("motion_fall", int'(fall), int'(m_fall));
    chk("hold_remaining", int'(hold), m_hold);
    chk("event_count", int'(ec), int'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    model_clear();
    check_outputs();
    steps(n);
    rst = 1'b0;
  endtask

  int lat;
  int glen;

  initial begin
    model_clear();
    m_k = 0;
    steps(3);
    rst = 1'b0;
    steps(8);

    // Clean rise: motion 7 cycles after GPIO step.
    gpio = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (lat == 0 && motion) lat = i;
    end
    chk("rise_latency", lat, 7);
    chk("first_event", int'(ec), 1);

    // Fall: motion_fall 37 cycles after GPIO drops.
    gpio = 1'b0;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (lat == 0 && fall) lat = i;
    end
    chk("fall_latency", lat, 37);
    chk("idle_hold", int'(hold), 0);

    // Short glitch is rejected.
    gpio = 1'b1;
    steps(3);
    gpio = 1'b0;
    steps(20);
    chk("glitch_motion", int'(motion), 0);
    chk("glitch_count", int'(ec), 1);

    // Re-rise during HOLD with 2 s left.
    gpio = 1'b1;
    steps(12);
    gpio = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      step();
      if (hold == 8'd2) lat = i;
    end
    chk("reach_hold2", int'(lat != 0), 1);
    gpio = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (lat == 0 && hold == 8'd0) lat = i;
    end
    chk("reacquire_latency", lat, 7);
    chk("reacquire_count", int'(ec), 2);
    chk("reacquire_motion", int'(motion), 1);

    // Reset in HOLD with GPIO held high afterwards.
    gpio = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      step();
      if (hold == 8'd2) lat = i;
    end
    gpio = 1'b1;
    do_reset(2);
    chk("rst_count", int'(ec), 0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (lat == 0 && motion) lat = i;
    end
    chk("post_reset_latency", lat, 7);

    // Randomized segments, glitches and resets.
    for (int s = 0; s < 160; s++) begin
      case ($urandom_range(0, 9))
        0: do_reset(int'($urandom_range(1, 3)));
        1, 2, 3: begin
          glen = int'($urandom_range(1, 3));
          gpio = ~gpio;
          steps(glen);
          gpio = ~gpio;
          steps(int'($urandom_range(1, 10)));
        end
        default: begin
          gpio = 1'($urandom_range(0, 1));
          steps(int'($urandom_range(1, 50)));
        end
      endcase
    end

    // Saturation: preset the counter near the top, then pulse.
    gpio = 1'b0;
    steps(60);
    force dut.event_count = 16'hFFFD;
    m_cnt = 32'hFFFD;
    step();
    release dut.event_count;
    for (int p = 0; p < 5; p++) begin
      gpio = 1'b1;
      steps(10);
      gpio = 1'b0;
      steps(45);
    end
    chk("saturated", int'(ec), 65535);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
